// File: rtl/phase_seq_pkg.sv
// Shared state codes, SEQTYPE encodings and parameter bounds for the
// PDP-8 major-state/phase sequencer.
package phase_seq_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 3'd0;
  localparam seq_state_t ST_FETCH = 3'd1;
  localparam seq_state_t ST_AUTO1 = 3'd2;
  localparam seq_state_t ST_AUTO2 = 3'd3;
  localparam seq_state_t ST_IND   = 3'd4;
  localparam seq_state_t ST_EXEC  = 3'd5;

  // 2'b10 is not listed and decodes as direct.
  localparam logic [1:0] SEQ_DIR   = 2'b00;
  localparam logic [1:0] SEQ_IND   = 2'b01;
  localparam logic [1:0] SEQ_PPIND = 2'b11;

  localparam int NPHASE_MIN = 2;
  localparam int NPHASE_MAX = 16;
  localparam int PCYC_MIN   = 2;
  localparam int PCYC_MAX   = 8;

endpackage

// File: rtl/phase_sequencer_timer.sv
// Per-phase cycle counter: flags the edge that ends a phase and whether
// the coming cycle is the last (strobe) cycle of its phase.
module phase_timer #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic active_nxt,
  output logic phase_adv,
  output logic phase_last
);
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] cyc, cyc_nxt;

  assign phase_adv = active && (cyc == CYC_LAST);

  // Every phase, including the first after IDLE, starts from cycle 0.
  always_comb begin
    if (!active || !active_nxt || cyc == CYC_LAST) cyc_nxt = '0;
    else                                           cyc_nxt = cyc + CW'(1);
  end

  assign phase_last = active_nxt && (cyc_nxt == CYC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc_nxt;
  end
endmodule

// File: rtl/phase_sequencer.sv
// PDP-8 major-state/phase sequencer: FETCH, optional AUTO1/AUTO2/IND, then
// up to NPHASE execute phases. Define SEQ_STEP_EN for single-instruction stepping.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NPHASE       = 6,
  parameter int PHASE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic              HALT,
  input  logic              STEP,
  input  logic              DONE,
  input  logic [1:0]        SEQTYPE,
  output logic              CK_FETCH,
  output logic              CK_AUTO1,
  output logic              CK_AUTO2,
  output logic              CK_IND,
  output logic              STB_FETCH,
  output logic              STB_AUTO1,
  output logic              STB_AUTO2,
  output logic              STB_IND,
  output logic [NPHASE-1:0] CK,
  output logic [NPHASE-1:0] STB,
  output logic              running,
  output logic              timeout
);
  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(NPHASE - 1);

  seq_state_t    st, st_nxt;
  logic [PW-1:0] ph, ph_nxt;
  logic          run_d, run_rise;
  logic          done_req, done_nxt;
  logic          halt_req, halt_nxt;
  logic          step_mode, step_nxt;
  logic          to_nxt, stop;
  logic          step_start, step_set;
  logic          active, active_nxt;
  logic          phase_adv, phase_last;
  logic [NPHASE-1:0] ex_ck;

  assign active     = (st != ST_IDLE);
  assign active_nxt = (st_nxt != ST_IDLE);
  assign run_rise   = RUN && !run_d;

  phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk        (CLK),
    .rst_n      (RESET),
    .active     (active),
    .active_nxt (active_nxt),
    .phase_adv  (phase_adv),
    .phase_last (phase_last)
  );

`ifdef SEQ_STEP_EN
  logic step_d, step_rise;
  assign step_rise  = STEP && !step_d;
  assign step_start = step_rise && !active && !run_rise && !HALT;
  assign step_set   = step_rise && active;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) step_d <= 1'b0;
    else        step_d <= STEP;
  end
`else
  logic unused_step;
  assign unused_step = STEP;
  assign step_start  = 1'b0;
  assign step_set    = 1'b0;
`endif

  always_comb begin
    st_nxt   = st;
    ph_nxt   = ph;
    done_nxt = done_req;
    to_nxt   = timeout;
    halt_nxt = halt_req | HALT;
    step_nxt = step_mode | step_set;
    stop     = 1'b0;
    case (st)
      ST_IDLE: begin
        if (run_rise && !HALT) begin
          st_nxt   = ST_FETCH;
          halt_nxt = 1'b0;
          to_nxt   = 1'b0;
        end else if (step_start) begin
          st_nxt   = ST_FETCH;
          halt_nxt = 1'b0;
          to_nxt   = 1'b0;
          step_nxt = 1'b1;
        end
      end
      ST_FETCH: begin
        if (phase_adv) begin
          case (SEQTYPE)
            SEQ_PPIND: st_nxt = ST_AUTO1;
            SEQ_IND:   st_nxt = ST_IND;
            default:   st_nxt = ST_EXEC;
          endcase
        end
      end
      ST_AUTO1: if (phase_adv) st_nxt = ST_AUTO2;
      ST_AUTO2: if (phase_adv) st_nxt = ST_IND;
      ST_IND:   if (phase_adv) st_nxt = ST_EXEC;
      ST_EXEC: begin
        if (DONE) done_nxt = 1'b1;
        if (phase_adv) begin
          done_nxt = 1'b0;
          // DONE in the strobe cycle still ends the instruction at this phase.
          if (done_req || DONE) begin
            if (halt_nxt || step_nxt) stop = 1'b1;
            else begin
              st_nxt = ST_FETCH;
              ph_nxt = '0;
            end
          end else if (ph == PH_LAST) begin
            to_nxt = 1'b1;
            stop   = 1'b1;
          end else begin
            ph_nxt = ph + PW'(1);
          end
        end
      end
      default: stop = 1'b1;
    endcase
    if (stop) begin
      st_nxt   = ST_IDLE;
      ph_nxt   = '0;
      halt_nxt = 1'b0;
      step_nxt = 1'b0;
    end
  end

  assign ex_ck = (st_nxt == ST_EXEC) ? (NPHASE'(1) << ph_nxt) : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st        <= ST_IDLE;
      ph        <= '0;
      run_d     <= 1'b0;
      done_req  <= 1'b0;
      halt_req  <= 1'b0;
      step_mode <= 1'b0;
      timeout   <= 1'b0;
      running   <= 1'b0;
      CK_FETCH  <= 1'b0;
      CK_AUTO1  <= 1'b0;
      CK_AUTO2  <= 1'b0;
      CK_IND    <= 1'b0;
      STB_FETCH <= 1'b0;
      STB_AUTO1 <= 1'b0;
      STB_AUTO2 <= 1'b0;
      STB_IND   <= 1'b0;
      CK        <= '0;
      STB       <= '0;
    end else begin
      st        <= st_nxt;
      ph        <= ph_nxt;
      run_d     <= RUN;
      done_req  <= done_nxt;
      halt_req  <= halt_nxt;
      step_mode <= step_nxt;
      timeout   <= to_nxt;
      running   <= active_nxt;
      // Outputs are decoded from the next state so they line up with st.
      CK_FETCH  <= (st_nxt == ST_FETCH);
      CK_AUTO1  <= (st_nxt == ST_AUTO1);
      CK_AUTO2  <= (st_nxt == ST_AUTO2);
      CK_IND    <= (st_nxt == ST_IND);
      STB_FETCH <= (st_nxt == ST_FETCH) && phase_last;
      STB_AUTO1 <= (st_nxt == ST_AUTO1) && phase_last;
      STB_AUTO2 <= (st_nxt == ST_AUTO2) && phase_last;
      STB_IND   <= (st_nxt == ST_IND)   && phase_last;
      CK        <= ex_ck;
      STB       <= phase_last ? ex_ck : '0;
    end
  end
endmodule
